seg_scanner: RTL and testbench
==============================

SEG_SCANNER -- requirements
Module: seg_scanner

Interface
REQ-001 Parameter NUM_DIG, default 8: number of scanned digits; legal range 1..8.
REQ-002 Parameter DIV_CNT, default 100000: clock cycles per digit slot; legal range >= 4.
REQ-003 Parameter BLANK_CNT, default 1000: blanking cycles at the start of each slot; legal range 1..DIV_CNT-2.
REQ-004 clk  input  1  system clock; all logic is on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 seg_data  input  64  segment codes; digit k occupies [8k+7:8k] as {a,b,c,d,e,f,g,dp}; active-low (0 = lit).
REQ-007 digit_mask  input  8  bit k = 1 enables digit k; bits >= NUM_DIG are ignored.
REQ-008 led_en  output  8  digit enables, active-low, one-hot-low while displaying.
REQ-009 led_seg  output  8  segment drive {a,b,c,d,e,f,g,dp}, active-low.
REQ-010 frame_start  output  1  single-cycle pulse marking the first output cycle of slot 0.

Function
REQ-011 cnt SHALL be a prescaler counting 0..DIV_CNT-1; at DIV_CNT-1 it SHALL wrap to 0 and advance slot.
REQ-012 slot SHALL count 0..NUM_DIG-1 and wrap from NUM_DIG-1 to 0.
REQ-013 On the edge where cnt==DIV_CNT-1 and slot==NUM_DIG-1, the block SHALL copy seg_data and digit_mask into shadow registers; the shadow SHALL hold between loads, so changes mid-frame do not tear the display.
REQ-014 Outputs SHALL be registered from the current (slot, cnt, shadow), giving exactly one cycle of latency from counter state to pins.
REQ-015 When cnt < BLANK_CNT, the registered outputs SHALL be led_en=8'hFF and led_seg=8'hFF (dead time against ghosting).
REQ-016 When cnt >= BLANK_CNT and shadow_mask[slot]=1, the outputs SHALL be led_en = all ones except bit slot = 0, and led_seg = shadow_seg[slot].
REQ-017 When cnt >= BLANK_CNT and shadow_mask[slot]=0, the outputs SHALL be led_en=8'hFF and led_seg=8'hFF.
REQ-018 led_en bits >= NUM_DIG SHALL always be 1.
REQ-019 frame_start SHALL be 1 for exactly the one output cycle that reflects slot=0, cnt=0, and 0 at all other times.
REQ-020 Each enabled digit SHALL be lit for exactly DIV_CNT-BLANK_CNT cycles per frame; the frame period SHALL be NUM_DIG*DIV_CNT cycles.
REQ-021 seg_data codes SHALL pass through unmodified; no decoding or validity checking is applied (8'hFF displays blank).

Reset
REQ-022 While rst=0: cnt=0, slot=0, shadow_seg=all ones, shadow_mask=0, led_en=8'hFF, led_seg=8'hFF, frame_start=0, applied asynchronously.
REQ-023 The first shadow load after reset release SHALL occur at the end of the first full frame; until then the display SHALL be blank.
REQ-024 Asserting reset mid-slot SHALL blank the outputs immediately and restart at slot 0, cnt 0 on release, with no partial pulse on frame_start.

Verification (NUM_DIG=2, DIV_CNT=8, BLANK_CNT=2 unless stated)
REQ-025 Reset release, seg_data[15:0]=16'h9F03, mask=2'b11 -> first frame (16 cycles) all 8'hFF; frame_start pulses at cycle 0 and cycle 16; cycles 18-23 led_en=8'hFE, led_seg=8'h03; cycles 26-31 led_en=8'hFD, led_seg=8'h9F.
REQ-026 Blanking -> in every slot the first 2 output cycles show led_en=8'hFF and led_seg=8'hFF, followed by exactly 6 lit cycles.
REQ-027 Change seg_data[7:0] from 8'h03 to 8'h25 mid-frame -> the displayed value stays 8'h03 until the next frame_start, then shows 8'h25.
REQ-028 mask=2'b10 -> digit 0 slot stays all 8'hFF; digit 1 slot lights normally; led_en[7:2] stay 1 throughout.
REQ-029 rst pulled low at slot 1, cnt 5 -> outputs go 8'hFF in the same cycle without a clock edge; after release, frame_start on the first output cycle and the display is blank for one frame.
REQ-030 NUM_DIG=8, DIV_CNT=4, BLANK_CNT=1 -> led_en walks FE,FD,...,7F, one slot every 4 cycles, with period 32 and frame_start every 32 cycles.

Source files
------------

// File: rtl/seg_scanner_if.sv
// Bundle between the segment-data source and the multiplexed LED driver.
// The source supplies codes and enables; the scanner drives the display pins.
interface seg_scanner_if;
    logic [63:0] seg_data;
    logic [7:0]  digit_mask;
    logic [7:0]  led_en;
    logic [7:0]  led_seg;
    logic        frame_start;

    modport master (
        output seg_data,
        output digit_mask,
        input  led_en,
        input  led_seg,
        input  frame_start
    );

    modport slave (
        input  seg_data,
        input  digit_mask,
        output led_en,
        output led_seg,
        output frame_start
    );
endinterface

// File: rtl/seg_scanner.sv
// Time-multiplexed 7-segment scanner: one digit per slot, blanking dead time at
// slot start, and frame-synchronous shadowing of the codes so the display never tears.
module seg_scanner #(
    parameter int NUM_DIG   = 8,
    parameter int DIV_CNT   = 100000,
    parameter int BLANK_CNT = 1000
) (
    input  logic          clk,
    input  logic          rst,
    seg_scanner_if.slave  bus
);

    localparam int               CNT_W     = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CNT);
    localparam logic [2:0]       SLOT_LAST = 3'(NUM_DIG - 1);
    localparam logic [7:0]       DIG_VALID = 8'((1 << NUM_DIG) - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       slot_q, slot_d;
    logic [63:0]      shadow_seg_q, shadow_seg_d;
    logic [7:0]       shadow_mask_q, shadow_mask_d;
    logic [7:0]       led_en_q, led_en_d;
    logic [7:0]       led_seg_q, led_seg_d;
    logic             frame_start_q, frame_start_d;

    logic slot_wrap;
    logic frame_end;
    logic lit;

    always_comb begin
        slot_wrap = (cnt_q == CNT_LAST);
        frame_end = slot_wrap && (slot_q == SLOT_LAST);

        cnt_d  = slot_wrap ? '0 : cnt_q + 1'b1;
        slot_d = slot_q;
        if (slot_wrap) begin
            slot_d = (slot_q == SLOT_LAST) ? 3'd0 : slot_q + 3'd1;
        end

        // Shadow only reloads on the very last cycle of a frame.
        shadow_seg_d  = frame_end ? bus.seg_data : shadow_seg_q;
        shadow_mask_d = frame_end ? (bus.digit_mask & DIG_VALID) : shadow_mask_q;

        lit       = (cnt_q >= CNT_BLANK) && shadow_mask_q[slot_q];
        led_en_d  = lit ? ~(8'd1 << slot_q) : 8'hFF;
        led_seg_d = lit ? shadow_seg_q[{slot_q, 3'b000} +: 8] : 8'hFF;

        frame_start_d = (cnt_q == '0) && (slot_q == 3'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q         <= '0;
            slot_q        <= 3'd0;
            shadow_seg_q  <= '1;
            shadow_mask_q <= '0;
            led_en_q      <= 8'hFF;
            led_seg_q     <= 8'hFF;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            slot_q        <= slot_d;
            shadow_seg_q  <= shadow_seg_d;
            shadow_mask_q <= shadow_mask_d;
            led_en_q      <= led_en_d;
            led_seg_q     <= led_seg_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.led_en      = led_en_q;
    assign bus.led_seg     = led_seg_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scanner.sv
// Bench for seg_scanner: a 2-digit and an 8-digit instance checked cycle by cycle
// against a frame/slot arithmetic model of the display schedule.
module tb_seg_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    seg_scanner_if ifa ();
    seg_scanner_if ifb ();

    seg_scanner #(.NUM_DIG(2), .DIV_CNT(8), .BLANK_CNT(2)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa.slave)
    );

    seg_scanner #(.NUM_DIG(8), .DIV_CNT(4), .BLANK_CNT(1)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int          t_a, t_b;
    logic [63:0] sh_seg_a, sh_seg_b;
    logic [7:0]  sh_mask_a, sh_mask_b;
    logic [7:0]  exp_en_a, exp_seg_a, exp_en_b, exp_seg_b;
    logic        exp_fs_a, exp_fs_b;

    // Output cycle t after reset release: position within the frame gives slot and
    // count; the digit is lit past the blanking window if its captured enable is set.
    function automatic void model(input int t, input int n, input int d, input int b,
                                  input logic [63:0] ss, input logic [7:0] sm,
                                  output logic [7:0] en, output logic [7:0] seg,
                                  output logic fs);
        int pos, slot, cnt;
        pos  = t % (n * d);
        slot = pos / d;
        cnt  = pos % d;
        fs   = (pos == 0);
        en   = 8'hFF;
        seg  = 8'hFF;
        if (cnt >= b && sm[slot]) begin
            en[slot] = 1'b0;
            seg      = ss[slot*8 +: 8];
        end
    endfunction

    task automatic advance_a();
        model(t_a, 2, 8, 2, sh_seg_a, sh_mask_a, exp_en_a, exp_seg_a, exp_fs_a);
        if (t_a % 16 == 15) begin
            sh_seg_a  = ifa.seg_data;
            sh_mask_a = ifa.digit_mask;
        end
        @(posedge clk);
        #1;
        t_a++;
    endtask

    task automatic advance_b();
        model(t_b, 8, 4, 1, sh_seg_b, sh_mask_b, exp_en_b, exp_seg_b, exp_fs_b);
        if (t_b % 32 == 31) begin
            sh_seg_b  = ifb.seg_data;
            sh_mask_b = ifb.digit_mask;
        end
        @(posedge clk);
        #1;
        t_b++;
    endtask

    task automatic reset_a();
        rst_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_a     = 1'b1;
        t_a       = 0;
        sh_seg_a  = '1;
        sh_mask_a = '0;
    endtask

    task automatic test_reset();
        rst_a = 1'b0;
        rst_b = 1'b0;
        ifa.seg_data = 64'h0;  ifa.digit_mask = 8'hFF;
        ifb.seg_data = 64'h0;  ifb.digit_mask = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({ifa.led_en, ifa.led_seg, ifa.frame_start} !== {8'hFF, 8'hFF, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_a got en=%h seg=%h fs=%b, want FF FF 0",
                     ifa.led_en, ifa.led_seg, ifa.frame_start);
        end
        n_cmp++;
        if ({ifb.led_en, ifb.led_seg, ifb.frame_start} !== {8'hFF, 8'hFF, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_b got en=%h seg=%h fs=%b, want FF FF 0",
                     ifb.led_en, ifb.led_seg, ifb.frame_start);
        end
    endtask

    task automatic test_first_frame();
        int lit0, lit1, blank_lead;
        ifa.seg_data   = {48'hFFFF_FFFF_FFFF, 16'h9F03};
        ifa.digit_mask = 8'h03;
        reset_a();
        lit0 = 0; lit1 = 0; blank_lead = 0;
        for (int i = 0; i < 48; i++) begin
            advance_a();
            n_cmp++;
            if ({ifa.led_en, ifa.led_seg, ifa.frame_start} !== {exp_en_a, exp_seg_a, exp_fs_a}) begin
                n_bad++;
                $display("FAIL first_frame t=%0d got en=%h seg=%h fs=%b, want %h %h %b",
                         t_a - 1, ifa.led_en, ifa.led_seg, ifa.frame_start,
                         exp_en_a, exp_seg_a, exp_fs_a);
            end
            if (t_a - 1 >= 16 && t_a - 1 < 32) begin
                if (ifa.led_en == 8'hFE && ifa.led_seg == 8'h03) lit0++;
                if (ifa.led_en == 8'hFD && ifa.led_seg == 8'h9F) lit1++;
                if (((t_a - 1) % 8) < 2 && ifa.led_en == 8'hFF && ifa.led_seg == 8'hFF) blank_lead++;
            end
        end
        n_cmp++;
        if (lit0 !== 6 || lit1 !== 6) begin
            n_bad++;
            $display("FAIL lit_count got %0d/%0d lit cycles, want 6/6", lit0, lit1);
        end
        n_cmp++;
        if (blank_lead !== 4) begin
            n_bad++;
            $display("FAIL blank_lead got %0d blank lead cycles, want 4", blank_lead);
        end
    endtask

    task automatic test_tear();
        ifa.seg_data   = {48'hFFFF_FFFF_FFFF, 16'h9F03};
        ifa.digit_mask = 8'h03;
        reset_a();
        while (t_a < 20) advance_a();
        ifa.seg_data[7:0] = 8'h25;
        while (t_a < 36) begin
            advance_a();
            n_cmp++;
            if ({ifa.led_en, ifa.led_seg, ifa.frame_start} !== {exp_en_a, exp_seg_a, exp_fs_a}) begin
                n_bad++;
                $display("FAIL tear t=%0d got en=%h seg=%h fs=%b, want %h %h %b",
                         t_a - 1, ifa.led_en, ifa.led_seg, ifa.frame_start,
                         exp_en_a, exp_seg_a, exp_fs_a);
            end
            if (t_a - 1 == 22) begin
                n_cmp++;
                if (ifa.led_seg !== 8'h03) begin
                    n_bad++;
                    $display("FAIL tear_hold got seg=%h, want 03", ifa.led_seg);
                end
            end
            if (t_a - 1 == 34) begin
                n_cmp++;
                if (ifa.led_seg !== 8'h25) begin
                    n_bad++;
                    $display("FAIL tear_update got seg=%h, want 25", ifa.led_seg);
                end
            end
        end
    endtask

    task automatic test_mask();
        ifa.seg_data   = {48'h0, 16'h4411};
        ifa.digit_mask = 8'hFE;
        reset_a();
        for (int i = 0; i < 48; i++) begin
            advance_a();
            n_cmp++;
            if ({ifa.led_en, ifa.led_seg, ifa.frame_start} !== {exp_en_a, exp_seg_a, exp_fs_a}) begin
                n_bad++;
                $display("FAIL mask t=%0d got en=%h seg=%h fs=%b, want %h %h %b",
                         t_a - 1, ifa.led_en, ifa.led_seg, ifa.frame_start,
                         exp_en_a, exp_seg_a, exp_fs_a);
            end
            if (ifa.led_en[7:1] !== 7'h7F && ifa.led_en !== 8'hFD) begin
                n_cmp++;
                n_bad++;
                $display("FAIL mask_high t=%0d got en=%h, want FF or FD", t_a - 1, ifa.led_en);
            end
        end
    endtask

    task automatic test_random();
        reset_a();
        ifa.seg_data   = {$urandom, $urandom};
        ifa.digit_mask = 8'($urandom);
        for (int i = 0; i < 320; i++) begin
            advance_a();
            n_cmp++;
            if ({ifa.led_en, ifa.led_seg, ifa.frame_start} !== {exp_en_a, exp_seg_a, exp_fs_a}) begin
                n_bad++;
                $display("FAIL random t=%0d got en=%h seg=%h fs=%b, want %h %h %b",
                         t_a - 1, ifa.led_en, ifa.led_seg, ifa.frame_start,
                         exp_en_a, exp_seg_a, exp_fs_a);
            end
            if ($urandom_range(0, 4) == 0) begin
                ifa.seg_data   = {$urandom, $urandom};
                ifa.digit_mask = 8'($urandom);
            end
        end
    endtask

    task automatic test_async_reset();
        ifa.seg_data   = {48'h0, 16'h8142};
        ifa.digit_mask = 8'h03;
        reset_a();
        while (t_a < 30) advance_a();
        n_cmp++;
        if (ifa.led_en !== 8'hFD || ifa.led_seg !== 8'h81) begin
            n_bad++;
            $display("FAIL pre_reset got en=%h seg=%h, want FD 81", ifa.led_en, ifa.led_seg);
        end
        #2;
        rst_a = 1'b0;
        #1;
        n_cmp++;
        if ({ifa.led_en, ifa.led_seg, ifa.frame_start} !== {8'hFF, 8'hFF, 1'b0}) begin
            n_bad++;
            $display("FAIL async_reset got en=%h seg=%h fs=%b, want FF FF 0",
                     ifa.led_en, ifa.led_seg, ifa.frame_start);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_a     = 1'b1;
        t_a       = 0;
        sh_seg_a  = '1;
        sh_mask_a = '0;
        for (int i = 0; i < 24; i++) begin
            advance_a();
            n_cmp++;
            if ({ifa.led_en, ifa.led_seg, ifa.frame_start} !== {exp_en_a, exp_seg_a, exp_fs_a}) begin
                n_bad++;
                $display("FAIL post_reset t=%0d got en=%h seg=%h fs=%b, want %h %h %b",
                         t_a - 1, ifa.led_en, ifa.led_seg, ifa.frame_start,
                         exp_en_a, exp_seg_a, exp_fs_a);
            end
        end
    endtask

    task automatic test_walk_b();
        int fs_count;
        ifb.seg_data   = {$urandom, $urandom};
        ifb.digit_mask = 8'hFF;
        rst_b     = 1'b1;
        t_b       = 0;
        sh_seg_b  = '1;
        sh_mask_b = '0;
        fs_count  = 0;
        for (int i = 0; i < 96; i++) begin
            advance_b();
            if (ifb.frame_start === 1'b1) fs_count++;
            n_cmp++;
            if ({ifb.led_en, ifb.led_seg, ifb.frame_start} !== {exp_en_b, exp_seg_b, exp_fs_b}) begin
                n_bad++;
                $display("FAIL walk t=%0d got en=%h seg=%h fs=%b, want %h %h %b",
                         t_b - 1, ifb.led_en, ifb.led_seg, ifb.frame_start,
                         exp_en_b, exp_seg_b, exp_fs_b);
            end
            if (t_b - 1 >= 32 && ((t_b - 1) % 4) != 0) begin
                n_cmp++;
                if (ifb.led_en !== ~(8'd1 << (((t_b - 1) % 32) / 4))) begin
                    n_bad++;
                    $display("FAIL walk_en t=%0d got en=%h", t_b - 1, ifb.led_en);
                end
            end
        end
        n_cmp++;
        if (fs_count !== 3) begin
            n_bad++;
            $display("FAIL walk_frames got %0d frame_start pulses, want 3", fs_count);
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_tear();
        test_mask();
        test_random();
        test_async_reset();
        test_walk_b();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
